// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: owner/state encodings and
// default bus widths.
package riscv_defs;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Latency counter holds MEM_LAT (1..7); starvation counter saturates at 15.
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory side bundle of the memory port arbiter. The master modport is the
// pipeline plus memory model; the slave modport is the arbiter itself.
interface mem_port_arbiter_if
    import riscv_defs::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Priority select between fetch and data requests, with a starvation counter that forces
// a fetch grant after STARVE_MAX consecutive data grants while fetch waits.
module mem_arb_prio
    import riscv_defs::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic port_free_i,
    output logic gnt_if_o,
    output logic gnt_d_o
);

    localparam logic [STARVE_W-1:0] StarveLim = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] StarveSat = '1;

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                if_starved;

    assign if_starved = if_req_i && (starve_cnt_q >= StarveLim);

    always_comb begin
        gnt_d_o  = 1'b0;
        gnt_if_o = 1'b0;
        if (port_free_i && !reset_i) begin
            if (d_req_i && !if_starved) begin
                gnt_d_o = 1'b1;
            end else if (if_req_i) begin
                gnt_if_o = 1'b1;
            end
        end

        // Count only data grants that overtake a waiting fetch.
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || gnt_if_o) begin
            starve_cnt_d = '0;
        end else if (gnt_d_o && (starve_cnt_q != StarveSat)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and the MEM
// stage, one access in flight at a time, with back-to-back issue on the response cycle.
module mem_port_arbiter
    import riscv_defs::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mem_port_arbiter_if.slave bus_io
);

    localparam logic [LAT_W-1:0] LatLoad = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LatOne  = LAT_W'(1);

    state_e            state_q;
    owner_e            owner_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic resp;
    logic port_free;
    logic gnt_if;
    logic gnt_d;
    logic grant;

    // The response cycle also frees the port so the next access can issue immediately.
    assign resp      = !reset_i && (state_q == ST_WAIT) && (lat_cnt_q == LatOne);
    assign port_free = (state_q == ST_IDLE) || (lat_cnt_q == LatOne);
    assign grant     = gnt_if || gnt_d;

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .if_req_i   (bus_io.if_req),
        .d_req_i    (bus_io.d_req),
        .port_free_i(port_free),
        .gnt_if_o   (gnt_if),
        .gnt_d_o    (gnt_d)
    );

    assign bus_io.if_gnt    = gnt_if;
    assign bus_io.d_gnt     = gnt_d;
    assign bus_io.mem_en    = grant;
    assign bus_io.mem_wen   = gnt_d && bus_io.d_wen;
    assign bus_io.mem_addr  = gnt_d  ? bus_io.d_addr  :
                              gnt_if ? bus_io.if_addr : mem_addr_q;
    assign bus_io.mem_wdata = grant ? bus_io.d_wdata : mem_wdata_q;

    assign bus_io.if_rvalid = resp && (owner_q == OWN_IF);
    assign bus_io.d_rvalid  = resp && (owner_q == OWN_D);
    assign bus_io.if_rdata  = bus_io.if_rvalid ? bus_io.mem_rdata : if_rdata_q;
    assign bus_io.d_rdata   = bus_io.d_rvalid  ? bus_io.mem_rdata : d_rdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            lat_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (grant) begin
                state_q     <= ST_WAIT;
                owner_q     <= gnt_d ? OWN_D : OWN_IF;
                lat_cnt_q   <= LatLoad;
                mem_addr_q  <= bus_io.mem_addr;
                mem_wdata_q <= bus_io.mem_wdata;
            end else if (state_q == ST_WAIT) begin
                if (lat_cnt_q == LatOne) begin
                    state_q   <= ST_IDLE;
                    lat_cnt_q <= '0;
                end else begin
                    lat_cnt_q <= lat_cnt_q - LatOne;
                end
            end

            if (bus_io.if_rvalid) begin
                if_rdata_q <= bus_io.mem_rdata;
            end
            if (bus_io.d_rvalid) begin
                d_rdata_q <= bus_io.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2 with a read/write memory
// model, one at MEM_LAT=1 with a read-only model for back-to-back alternating traffic.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_a ();
    mem_port_arbiter_if bus_b ();

    mem_port_arbiter #(
        .MEM_LAT   (2),
        .STARVE_MAX(4)
    ) u_dut_a (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus_a.slave)
    );

    mem_port_arbiter #(
        .MEM_LAT   (1),
        .STARVE_MAX(4)
    ) u_dut_b (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus_b.slave)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory A: two-stage read pipeline, stores remembered until reset.
    logic [31:0]   mem_a [1024];
    logic [1023:0] wr_a;
    logic [31:0]   rd_a_q [2];
    logic [9:0]    idx_a;
    assign idx_a = bus_a.mem_addr[11:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_a <= '0;
        end else if (bus_a.mem_en && bus_a.mem_wen) begin
            mem_a[idx_a] <= bus_a.mem_wdata;
            wr_a[idx_a]  <= 1'b1;
        end
        rd_a_q[0] <= wr_a[idx_a] ? mem_a[idx_a] : init_word(bus_a.mem_addr);
        rd_a_q[1] <= rd_a_q[0];
    end
    assign bus_a.mem_rdata = rd_a_q[1];

    logic [31:0] rd_b_q;
    always_ff @(posedge clk) rd_b_q <= init_word(bus_b.mem_addr);
    assign bus_b.mem_rdata = rd_b_q;

    a_if_hold: assert property (@(posedge clk) disable iff (reset)
        (bus_a.if_req && !bus_a.if_gnt) |=> bus_a.if_req);
    a_d_hold: assert property (@(posedge clk) disable iff (reset)
        (bus_a.d_req && !bus_a.d_gnt) |=> bus_a.d_req);
    a_excl: assert property (@(posedge clk) !(bus_a.if_gnt && bus_a.d_gnt));
    b_excl: assert property (@(posedge clk) !(bus_b.if_gnt && bus_b.d_gnt));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // {if_gnt, d_gnt} per cycle of the starvation sequence.
    localparam logic [1:0] StarveExp [15] = '{
        2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
        2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00
    };

    logic [5:0] flags_a;
    assign flags_a = {bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid,
                      bus_a.mem_en, bus_a.mem_wen};

    initial begin
        bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.d_req = 1'b0; bus_a.d_wen = 1'b0;
        bus_a.d_addr = '0;   bus_a.d_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.d_req = 1'b0; bus_b.d_wen = 1'b0;
        bus_b.d_addr = '0;   bus_b.d_wdata = '0;

        // Reset: requests present but everything gated.
        tick();
        tick();
        bus_a.if_req = 1'b1; bus_a.d_req = 1'b1; bus_a.if_addr = 32'h100;
        settle();
        check_eq("rst_flags", flags_a, 6'b0);
        check_eq("rst_mem_addr", bus_a.mem_addr, 32'h0);
        check_eq("rst_if_rdata", bus_a.if_rdata, 32'h0);
        check_eq("rst_d_rdata", bus_a.d_rdata, 32'h0);

        // IF-only fetch of 0x100.
        tick();
        reset = 1'b0; bus_a.d_req = 1'b0;
        settle();
        check_eq("f_if_gnt", {bus_a.if_gnt, bus_a.d_gnt}, 2'b10);
        check_eq("f_mem_en", {bus_a.mem_en, bus_a.mem_wen}, 2'b10);
        check_eq("f_mem_addr", bus_a.mem_addr, 32'h100);
        tick();
        bus_a.if_req = 1'b0;
        settle();
        check_eq("f_wait", flags_a, 6'b0);
        check_eq("f_addr_hold", bus_a.mem_addr, 32'h100);
        tick(); settle();
        check_eq("f_rvalid", {bus_a.if_rvalid, bus_a.d_rvalid}, 2'b10);
        check_eq("f_rdata", bus_a.if_rdata, init_word(32'h100));
        tick(); settle();
        check_eq("f_rvalid_off", bus_a.if_rvalid, 1'b0);
        check_eq("f_rdata_hold", bus_a.if_rdata, init_word(32'h100));

        // Store and fetch arrive together: data first, fetch back-to-back on response.
        tick();
        bus_a.d_req = 1'b1; bus_a.d_wen = 1'b1; bus_a.d_addr = 32'h200;
        bus_a.d_wdata = 32'hDEAD_BEEF; bus_a.if_req = 1'b1; bus_a.if_addr = 32'h104;
        settle();
        check_eq("s_gnt", {bus_a.if_gnt, bus_a.d_gnt}, 2'b01);
        check_eq("s_mem_wen", {bus_a.mem_en, bus_a.mem_wen}, 2'b11);
        check_eq("s_mem_addr", bus_a.mem_addr, 32'h200);
        check_eq("s_mem_wdata", bus_a.mem_wdata, 32'hDEAD_BEEF);
        tick();
        bus_a.d_req = 1'b0; bus_a.d_wen = 1'b0;
        settle();
        check_eq("s_busy", {bus_a.if_gnt, bus_a.mem_en}, 2'b00);
        tick(); settle();
        check_eq("s_rvalid", bus_a.d_rvalid, 1'b1);
        check_eq("s_if_gnt", {bus_a.if_gnt, bus_a.mem_en, bus_a.mem_wen}, 3'b110);
        check_eq("s_if_addr", bus_a.mem_addr, 32'h104);
        check_eq("s_starve1", u_dut_a.u_prio.starve_cnt_q, 4'd1);
        tick();
        bus_a.if_req = 1'b0;
        settle();
        check_eq("s_if_wait", bus_a.if_rvalid, 1'b0);
        check_eq("s_starve0", u_dut_a.u_prio.starve_cnt_q, 4'd0);
        tick(); settle();
        check_eq("s_if_rvalid", bus_a.if_rvalid, 1'b1);
        check_eq("s_if_rdata", bus_a.if_rdata, init_word(32'h104));

        // Six loads held against a waiting fetch: 4 data grants, then fetch, then data.
        tick();
        bus_a.d_req = 1'b1; bus_a.d_wen = 1'b0; bus_a.d_addr = 32'h200;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h300;
        begin
            int n_ld = 0;
            for (int k = 0; k < 15; k++) begin
                logic gd, gi;
                settle();
                check_eq($sformatf("st_gnt%0d", k), {bus_a.if_gnt, bus_a.d_gnt}, StarveExp[k]);
                if (k == 2) check_eq("st_ld0", {bus_a.d_rvalid, bus_a.d_rdata}, {1'b1, 32'hDEAD_BEEF});
                if (k == 4) check_eq("st_ld1", {bus_a.d_rvalid, bus_a.d_rdata},
                                     {1'b1, init_word(32'h204)});
                if (k == 8) check_eq("st_cnt_max", u_dut_a.u_prio.starve_cnt_q, 4'd4);
                if (k == 9) check_eq("st_cnt_clr", u_dut_a.u_prio.starve_cnt_q, 4'd0);
                if (k == 10) check_eq("st_if", {bus_a.if_rvalid, bus_a.if_rdata},
                                      {1'b1, init_word(32'h300)});
                if (k == 12) check_eq("st_ld4", {bus_a.d_rvalid, bus_a.d_rdata},
                                      {1'b1, init_word(32'h210)});
                if (k == 14) check_eq("st_ld5", {bus_a.d_rvalid, bus_a.d_rdata},
                                      {1'b1, init_word(32'h214)});
                gd = bus_a.d_gnt;
                gi = bus_a.if_gnt;
                tick();
                if (gd) begin
                    n_ld++;
                    bus_a.d_addr = 32'h200 + 32'(4 * n_ld);
                    if (n_ld == 6) bus_a.d_req = 1'b0;
                end
                if (gi) bus_a.if_req = 1'b0;
            end
        end

        // Reset one cycle after a load grant: the response must never appear.
        bus_a.d_req = 1'b1; bus_a.d_addr = 32'h208;
        settle();
        check_eq("r_d_gnt", bus_a.d_gnt, 1'b1);
        tick();
        reset = 1'b1; bus_a.d_req = 1'b0;
        settle();
        check_eq("r_in_rst", flags_a, 6'b0);
        tick();
        reset = 1'b0; bus_a.if_req = 1'b1; bus_a.if_addr = 32'h400;
        settle();
        check_eq("r_no_rvalid", bus_a.d_rvalid, 1'b0);
        check_eq("r_idle", u_dut_a.state_q, 1'b0);
        check_eq("r_d_rdata", bus_a.d_rdata, 32'h0);
        check_eq("r_if_gnt", {bus_a.if_gnt, bus_a.mem_en}, 2'b11);
        check_eq("r_if_addr", bus_a.mem_addr, 32'h400);
        tick();
        bus_a.if_req = 1'b0;
        settle();
        check_eq("r_wait", {bus_a.if_rvalid, bus_a.d_rvalid}, 2'b00);
        tick(); settle();
        check_eq("r_if_rvalid", {bus_a.if_rvalid, bus_a.d_rvalid}, 2'b10);
        check_eq("r_if_rdata", bus_a.if_rdata, init_word(32'h400));

        // Ten idle cycles.
        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            check_eq($sformatf("idle_flags%0d", i), flags_a, 6'b0);
            check_eq($sformatf("idle_starve%0d", i), u_dut_a.u_prio.starve_cnt_q, 4'd0);
        end

        // MEM_LAT=1: alternate data/fetch requests every cycle.
        for (int k = 0; k < 9; k++) begin
            logic [31:0] exp_addr;
            tick();
            bus_b.d_req  = (k < 8) && (k % 2 == 0);
            bus_b.if_req = (k < 8) && (k % 2 == 1);
            bus_b.d_addr  = 32'h500 + 32'(4 * k);
            bus_b.if_addr = 32'h600 + 32'(4 * k);
            exp_addr = (k % 2 == 0) ? bus_b.d_addr : bus_b.if_addr;
            settle();
            if (k < 8) begin
                check_eq($sformatf("alt_gnt%0d", k), {bus_b.if_gnt, bus_b.d_gnt, bus_b.mem_en},
                         (k % 2 == 0) ? 3'b011 : 3'b101);
                check_eq($sformatf("alt_addr%0d", k), bus_b.mem_addr, exp_addr);
            end
            if (k == 0) begin
                check_eq("alt_rv0", {bus_b.if_rvalid, bus_b.d_rvalid}, 2'b00);
            end else if ((k - 1) % 2 == 0) begin
                check_eq($sformatf("alt_drv%0d", k), {bus_b.if_rvalid, bus_b.d_rvalid, bus_b.d_rdata},
                         {2'b01, init_word(32'h500 + 32'(4 * (k - 1)))});
            end else begin
                check_eq($sformatf("alt_irv%0d", k), {bus_b.if_rvalid, bus_b.d_rvalid, bus_b.if_rdata},
                         {2'b10, init_word(32'h600 + 32'(4 * (k - 1)))});
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
